// File: rtl/clkgate_ctrl_if.sv
// Request/acknowledge bundle between the requesters and the clock-gate sequencer.
interface clkgate_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] i_req;
    logic [NUM_REQ-1:0] o_ack;

    modport master (output i_req, input o_ack);
    modport slave  (input i_req, output o_ack);
endinterface

// File: rtl/clkgate_ctrl.sv
// Idle-driven enable sequencer for one gated clock domain shared by NUM_REQ requesters.
// Optional statistics counters are included when CLKGATE_CTRL_STATS_EN is defined.
module clkgate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [IDLE_CNT_W-1:0] i_idle_thresh,
    input  logic                  i_force_on,
    input  logic                  i_busy,
    clkgate_ctrl_if.slave         req_if,
    output logic                  o_clk_en,
    output logic [1:0]            o_state
`ifdef CLKGATE_CTRL_STATS_EN
    ,
    output logic [15:0]           o_wake_cnt,
    output logic [31:0]           o_off_cycles
`endif
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

    state_t                r_state;
    logic [3:0]            r_wake_cnt;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic                  r_clk_en;

    logic                  w_activity;
    logic [IDLE_CNT_W:0]   w_idle_next;
    logic                  w_idle_reached;
    logic [IDLE_CNT_W-1:0] w_idle_sat;

    assign w_activity     = (|req_if.i_req) | i_busy | i_force_on;
    // One extra bit so the threshold compare stays correct when idle_cnt is all-ones.
    assign w_idle_next    = {1'b0, r_idle_cnt} + {{IDLE_CNT_W{1'b0}}, 1'b1};
    assign w_idle_reached = (w_idle_next >= {1'b0, i_idle_thresh});
    assign w_idle_sat     = (&r_idle_cnt) ? r_idle_cnt : w_idle_next[IDLE_CNT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_OFF;
            r_clk_en   <= 1'b0;
            r_wake_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (w_activity) begin
                        r_state    <= S_WAKE;
                        r_clk_en   <= 1'b1;
                        r_wake_cnt <= '0;
                    end
                end
                S_WAKE: begin
                    r_clk_en <= 1'b1;
                    if (r_wake_cnt == WAKE_LAST) begin
                        r_state    <= S_ON;
                        r_wake_cnt <= '0;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 4'd1;
                    end
                end
                S_ON: begin
                    r_clk_en <= 1'b1;
                    if (!w_activity && (i_idle_thresh != '0)) begin
                        r_state    <= S_IDLE;
                        r_idle_cnt <= '0;
                    end
                end
                S_IDLE: begin
                    // Activity outranks both the threshold and the disable check.
                    if (w_activity) begin
                        r_state    <= S_ON;
                        r_clk_en   <= 1'b1;
                        r_idle_cnt <= '0;
                    end else if (i_idle_thresh == '0) begin
                        r_state    <= S_ON;
                        r_clk_en   <= 1'b1;
                        r_idle_cnt <= '0;
                    end else if (w_idle_reached) begin
                        r_state    <= S_OFF;
                        r_clk_en   <= 1'b0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_clk_en   <= 1'b1;
                        r_idle_cnt <= w_idle_sat;
                    end
                end
                default: begin
                    r_state  <= S_OFF;
                    r_clk_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_if.o_ack = req_if.i_req & {NUM_REQ{r_state == S_ON}};
    assign o_clk_en     = r_clk_en;
    assign o_state      = r_state;

`ifdef CLKGATE_CTRL_STATS_EN
    logic [15:0] r_wake_events;
    logic [31:0] r_off_cycles;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wake_events <= '0;
            r_off_cycles  <= '0;
        end else if (r_state == S_OFF) begin
            if (!(&r_off_cycles)) begin
                r_off_cycles <= r_off_cycles + 32'd1;
            end
            if (w_activity && !(&r_wake_events)) begin
                r_wake_events <= r_wake_events + 16'd1;
            end
        end
    end

    assign o_wake_cnt   = r_wake_events;
    assign o_off_cycles = r_off_cycles;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed scoreboard bench for clkgate_ctrl (NUM_REQ=4, IDLE_CNT_W=8, WAKE_CYCLES=2).
module tb_clkgate_ctrl;

    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] WAKE = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] IDLE = 2'd3;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       en;
        logic [3:0] ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] thresh;
    logic       forceOn;
    logic       busy;
    logic       clkEn;
    logic [1:0] state;
`ifdef CLKGATE_CTRL_STATS_EN
    logic [15:0] wakeCnt;
    logic [31:0] offCycles;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    clkgate_ctrl_if #(.NUM_REQ(4)) reqIf ();

    clkgate_ctrl #(
        .NUM_REQ(4),
        .IDLE_CNT_W(8),
        .WAKE_CYCLES(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_idle_thresh(thresh),
        .i_force_on(forceOn),
        .i_busy(busy),
        .req_if(reqIf.slave),
        .o_clk_en(clkEn),
        .o_state(state)
`ifdef CLKGATE_CTRL_STATS_EN
        ,
        .o_wake_cnt(wakeCnt),
        .o_off_cycles(offCycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (state === e.st) else begin
                errors++;
                $error("[TB] FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
            end
            checks++;
            assert (clkEn === e.en) else begin
                errors++;
                $error("[TB] FAIL %s.clk_en observed=%0b expected=%0b", e.tag, clkEn, e.en);
            end
            checks++;
            assert (reqIf.o_ack === e.ack) else begin
                errors++;
                $error("[TB] FAIL %s.ack observed=%b expected=%b", e.tag, reqIf.o_ack, e.ack);
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] req, input logic bsy,
                                 input logic frc, input logic [7:0] thr, input logic rst,
                                 input logic [1:0] expSt, input logic expEn,
                                 input logic [3:0] expAck);
        exp_t e;
        reqIf.i_req = req;
        busy        = bsy;
        forceOn     = frc;
        thresh      = thr;
        rstN        = rst;
        e.tag = tag;
        e.st  = expSt;
        e.en  = expEn;
        e.ack = expAck;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reqIf.i_req = 4'b0;
        busy        = 1'b0;
        forceOn     = 1'b0;
        thresh      = 8'd0;
        rstN        = 1'b0;

        $display("[TB] reset and quiet");
        applyStimulus("rst0", 4'b0000, 0, 0, 8'd0, 0, OFF, 0, 4'b0000);
        applyStimulus("rst1", 4'b0000, 0, 0, 8'd0, 0, OFF, 0, 4'b0000);
        for (int i = 0; i < 20; i++)
            applyStimulus("quiet", 4'b0000, 0, 0, 8'd5, 1, OFF, 0, 4'b0000);

        $display("[TB] wake from OFF");
        applyStimulus("wake1", 4'b0010, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("wake2", 4'b0010, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("wake3", 4'b0010, 0, 0, 8'd5, 1, ON,   1, 4'b0010);
        applyStimulus("multi", 4'b1010, 0, 0, 8'd5, 1, ON,   1, 4'b1010);

        $display("[TB] idle to off, thresh 5");
        applyStimulus("idleIn", 4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        for (int i = 0; i < 4; i++)
            applyStimulus("idle", 4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        applyStimulus("gateOff", 4'b0000, 0, 0, 8'd5, 1, OFF, 0, 4'b0000);
        applyStimulus("offHold", 4'b0000, 0, 0, 8'd5, 1, OFF, 0, 4'b0000);

        $display("[TB] busy rescues idle");
        applyStimulus("rw1", 4'b0001, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("rw2", 4'b0001, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("rw3", 4'b0001, 0, 0, 8'd5, 1, ON,   1, 4'b0001);
        applyStimulus("rIdleIn", 4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        for (int i = 0; i < 4; i++)
            applyStimulus("rIdle", 4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        applyStimulus("busyWake", 4'b0000, 1, 0, 8'd5, 1, ON,   1, 4'b0000);
        applyStimulus("busyHold", 4'b0000, 1, 0, 8'd5, 1, ON,   1, 4'b0000);
        applyStimulus("busyDrop", 4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        applyStimulus("idleReq",  4'b0100, 0, 0, 8'd5, 1, ON,   1, 4'b0100);

        $display("[TB] lowering thresh below idle count");
        applyStimulus("lIdleIn", 4'b0000, 0, 0, 8'd200, 1, IDLE, 1, 4'b0000);
        for (int i = 0; i < 10; i++)
            applyStimulus("lIdle", 4'b0000, 0, 0, 8'd200, 1, IDLE, 1, 4'b0000);
        applyStimulus("lower", 4'b0000, 0, 0, 8'd3, 1, OFF, 0, 4'b0000);

        $display("[TB] thresh 0 disables gating");
        applyStimulus("tw1", 4'b0001, 0, 0, 8'd200, 1, WAKE, 1, 4'b0000);
        applyStimulus("tw2", 4'b0001, 0, 0, 8'd200, 1, WAKE, 1, 4'b0000);
        applyStimulus("tw3", 4'b0001, 0, 0, 8'd200, 1, ON,   1, 4'b0001);
        applyStimulus("tIdleIn", 4'b0000, 0, 0, 8'd200, 1, IDLE, 1, 4'b0000);
        applyStimulus("tIdle", 4'b0000, 0, 0, 8'd200, 1, IDLE, 1, 4'b0000);
        applyStimulus("tIdle", 4'b0000, 0, 0, 8'd200, 1, IDLE, 1, 4'b0000);
        applyStimulus("thr0Idle", 4'b0000, 0, 0, 8'd0, 1, ON, 1, 4'b0000);
        for (int i = 0; i < 300; i++)
            applyStimulus("thr0Hold", 4'b0000, 0, 0, 8'd0, 1, ON, 1, 4'b0000);

        $display("[TB] force on holds clock");
        for (int i = 0; i < 300; i++)
            applyStimulus("forceHold", 4'b0000, 0, 1, 8'd5, 1, ON, 1, 4'b0000);
        applyStimulus("thr1In",  4'b0000, 0, 0, 8'd1, 1, IDLE, 1, 4'b0000);
        applyStimulus("thr1Off", 4'b0000, 0, 0, 8'd1, 1, OFF,  0, 4'b0000);

        $display("[TB] reset during WAKE");
        applyStimulus("mw1",   4'b0010, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("mwRst", 4'b0010, 0, 0, 8'd5, 0, OFF,  0, 4'b0000);
        applyStimulus("mw2",   4'b0010, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("mw3",   4'b0010, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("mw4",   4'b0010, 0, 0, 8'd5, 1, ON,   1, 4'b0010);

        $display("[TB] reset during IDLE");
        applyStimulus("miIn",  4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        applyStimulus("mi",    4'b0000, 0, 0, 8'd5, 1, IDLE, 1, 4'b0000);
        applyStimulus("miRst", 4'b0000, 0, 0, 8'd5, 0, OFF,  0, 4'b0000);
        applyStimulus("mw5",   4'b1000, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("mw6",   4'b1000, 0, 0, 8'd5, 1, WAKE, 1, 4'b0000);
        applyStimulus("mw7",   4'b1000, 0, 0, 8'd5, 1, ON,   1, 4'b1000);
        applyStimulus("busyOn", 4'b0000, 1, 0, 8'd5, 1, ON,  1, 4'b0000);

`ifdef CLKGATE_CTRL_STATS_EN
        $display("[TB] statistics counters");
        applyStimulus("sRst", 4'b0000, 0, 0, 8'd4, 0, OFF, 0, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++)
                applyStimulus("sOff", 4'b0000, 0, 0, 8'd4, 1, OFF, 0, 4'b0000);
            applyStimulus("sW1", 4'b0001, 0, 0, 8'd4, 1, WAKE, 1, 4'b0000);
            applyStimulus("sW2", 4'b0001, 0, 0, 8'd4, 1, WAKE, 1, 4'b0000);
            applyStimulus("sW3", 4'b0001, 0, 0, 8'd4, 1, ON,   1, 4'b0001);
            if (k < 2) begin
                applyStimulus("sIdleIn", 4'b0000, 0, 0, 8'd4, 1, IDLE, 1, 4'b0000);
                for (int i = 0; i < 3; i++)
                    applyStimulus("sIdle", 4'b0000, 0, 0, 8'd4, 1, IDLE, 1, 4'b0000);
                applyStimulus("sGate", 4'b0000, 0, 0, 8'd4, 1, OFF, 0, 4'b0000);
            end
        end
        checks++;
        assert (wakeCnt === 16'd3) else begin
            errors++;
            $error("[TB] FAIL wake_cnt observed=%0d expected=3", wakeCnt);
        end
        checks++;
        assert (offCycles === 32'd30) else begin
            errors++;
            $error("[TB] FAIL off_cycles observed=%0d expected=30", offCycles);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
